// File: rtl/convolution_3x3.sv
// rtl/convolution_3x3.sv - pipelined 3x3 convolution with built-in kernel table
// Window -> multiply -> accumulate -> normalise/clamp, valid and coordinates ride alongside.

module kernels #(
  parameter int K_SELECT = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  output logic [2:0][2:0][7:0] coeffs,
  output logic [3:0]           shift
);
  logic [2:0][2:0][7:0] coeffs_d, coeffs_q;
  logic [3:0]           shift_d, shift_q;

  // Concatenation order is [2][2],[2][1],[2][0],[1][2],... ; c=0 is the oldest column.
  always_comb begin
    coeffs_d = '0;
    shift_d  = '0;
    case (K_SELECT)
      1: begin
        coeffs_d = {8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h02, 8'h01};
        shift_d  = 4'd4;
      end
      2: coeffs_d = {8'h00, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h00};
      3: coeffs_d = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      4: coeffs_d = {8'hFF, 8'h00, 8'h01, 8'hFE, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h01};
      5: coeffs_d = {8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01};
      default: coeffs_d[1][1] = 8'h01;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      coeffs_q <= '0;
      shift_q  <= '0;
    end else begin
      coeffs_q <= coeffs_d;
      shift_q  <= shift_d;
    end
  end

  assign coeffs = coeffs_q;
  assign shift  = shift_q;
endmodule

module convolution_3x3 #(
  parameter int K_SELECT = 0,
  parameter int HCOUNT_W = 11,
  parameter int VCOUNT_W = 10
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                data_valid_in,
  input  logic [2:0][7:0]     line_buffer_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic                data_valid_out,
  output logic [7:0]          line_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out
);
  logic [2:0][2:0][7:0] coeffs;
  logic [3:0]           shift;

  kernels #(.K_SELECT(K_SELECT)) u_kernels (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .coeffs (coeffs),
    .shift  (shift)
  );

  logic [2:0][2:0][7:0]  win_d, win_q;
  logic [HCOUNT_W-1:0]   hprev_d, hprev_q;
  logic                  v0_d, v0_q, v1_d, v1_q, v2_d, v2_q, vout_d, vout_q;
  logic [HCOUNT_W-1:0]   hc0_d, hc0_q, hc1_d, hc1_q, hc2_d, hc2_q, hco_d, hco_q;
  logic [VCOUNT_W-1:0]   vc0_d, vc0_q, vc1_d, vc1_q, vc2_d, vc2_q, vco_d, vco_q;
  logic [2:0][2:0][16:0] prod_d, prod_q;
  logic signed [20:0]    sum_d, sum_q, acc, shifted;
  logic [7:0]            clamped, line_d, line_q;

  function automatic logic [16:0] mul(input logic [7:0] s, input logic [7:0] k);
    logic signed [16:0] a, b;
    a = $signed({9'b0, s});
    b = $signed({{9{k[7]}}, k});
    mul = a * b;
  endfunction

  always_comb begin
    win_d   = win_q;
    hprev_d = hprev_q;
    hc0_d   = hc0_q;
    vc0_d   = vc0_q;
    v0_d    = data_valid_in;
    if (data_valid_in) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        win_d[r][2] = line_buffer_in[r];
      end
      // Centre column is the previous valid one, so its hcount is the delayed value.
      hprev_d = hcount_in;
      hc0_d   = hprev_q;
      vc0_d   = vcount_in;
    end

    prod_d = prod_q;
    hc1_d  = hc1_q;
    vc1_d  = vc1_q;
    v1_d   = v0_q;
    if (v0_q) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          prod_d[r][c] = mul(win_q[r][c], coeffs[r][c]);
      hc1_d = hc0_q;
      vc1_d = vc0_q;
    end

    acc = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc = acc + $signed({{4{prod_q[r][c][16]}}, prod_q[r][c]});
    sum_d = v1_q ? acc : sum_q;
    hc2_d = v1_q ? hc1_q : hc2_q;
    vc2_d = v1_q ? vc1_q : vc2_q;
    v2_d  = v1_q;

    shifted = sum_q >>> shift;
    if (shifted[20])
      clamped = 8'h00;
    else if (shifted > 21'sd255)
      clamped = 8'hFF;
    else
      clamped = shifted[7:0];
    line_d = v2_q ? clamped : line_q;
    hco_d  = v2_q ? hc2_q : hco_q;
    vco_d  = v2_q ? vc2_q : vco_q;
    vout_d = v2_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      win_q   <= '0;
      hprev_q <= '0;
      v0_q    <= 1'b0;
      hc0_q   <= '0;
      vc0_q   <= '0;
      prod_q  <= '0;
      v1_q    <= 1'b0;
      hc1_q   <= '0;
      vc1_q   <= '0;
      sum_q   <= '0;
      v2_q    <= 1'b0;
      hc2_q   <= '0;
      vc2_q   <= '0;
      line_q  <= '0;
      vout_q  <= 1'b0;
      hco_q   <= '0;
      vco_q   <= '0;
    end else begin
      win_q   <= win_d;
      hprev_q <= hprev_d;
      v0_q    <= v0_d;
      hc0_q   <= hc0_d;
      vc0_q   <= vc0_d;
      prod_q  <= prod_d;
      v1_q    <= v1_d;
      hc1_q   <= hc1_d;
      vc1_q   <= vc1_d;
      sum_q   <= sum_d;
      v2_q    <= v2_d;
      hc2_q   <= hc2_d;
      vc2_q   <= vc2_d;
      line_q  <= line_d;
      vout_q  <= vout_d;
      hco_q   <= hco_d;
      vco_q   <= vco_d;
    end
  end

  assign data_valid_out = vout_q;
  assign line_out       = line_q;
  assign hcount_out     = hco_q;
  assign vcount_out     = vco_q;
endmodule

// File: tb/tb_convolution_3x3.sv
// tb/tb_convolution_3x3.sv - scoreboard bench running all six kernels side by side

module tb_convolution_3x3;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             vin = 1'b0;
  logic [2:0][7:0]  lb = '0;
  logic [10:0]      hcin = '0;
  logic [9:0]       vcin = '0;
  logic [5:0]       dv_out;
  logic [5:0][7:0]  line_out;
  logic [5:0][10:0] hc_out;
  logic [5:0][9:0]  vc_out;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    convolution_3x3 #(.K_SELECT(g), .HCOUNT_W(11), .VCOUNT_W(10)) u_dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .data_valid_in  (vin),
      .line_buffer_in (lb),
      .hcount_in      (hcin),
      .vcount_in      (vcin),
      .data_valid_out (dv_out[g]),
      .line_out       (line_out[g]),
      .hcount_out     (hc_out[g]),
      .vcount_out     (vc_out[g])
    );
  end

  typedef struct {
    logic [5:0][7:0] line;
    logic [10:0]     hc;
    logic [9:0]      vc;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic rst_seen = 1'b1;
  int   mwin[3][3];
  logic [10:0] mhprev = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int coef(int k, int r, int c);
    case (k)
      0: return (r == 1 && c == 1) ? 1 : 0;
      1: return (r == 1 ? 2 : 1) * (c == 1 ? 2 : 1);
      2: return (r == 1 && c == 1) ? 5 : ((r == 1 || c == 1) ? -1 : 0);
      3: return (r == 1 && c == 1) ? 8 : -1;
      4: return (1 - c) * (r == 1 ? 2 : 1);
      default: return (1 - r) * (c == 1 ? 2 : 1);
    endcase
  endfunction

  function automatic logic [7:0] model(int k);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += mwin[r][c] * coef(k, r, c);
    s = s >>> ((k == 1) ? 4 : 0);
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  task automatic model_clear();
    sb.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mwin[r][c] = 0;
    mhprev = '0;
  endtask

  task automatic drive(input logic v, input logic [7:0] t, input logic [7:0] m,
                       input logic [7:0] b, input logic [10:0] hc, input logic [9:0] vc);
    exp_t e;
    @(negedge clk);
    vin  = v;
    lb   = {b, m, t};
    hcin = hc;
    vcin = vc;
    if (v) begin
      for (int r = 0; r < 3; r++) begin
        mwin[r][0] = mwin[r][1];
        mwin[r][1] = mwin[r][2];
        mwin[r][2] = int'(lb[r]);
      end
      e.hc  = mhprev;
      mhprev = hc;
      e.vc  = vc;
      e.cyc = cyc + 4;
      for (int k = 0; k < 6; k++) e.line[k] = model(k);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 11'($urandom), 10'($urandom));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dv"}, 32'(dv_out), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check({tag, "_line"}, 32'(line_out[k]), 32'd0);
      check({tag, "_hc"}, 32'(hc_out[k]), 32'd0);
      check({tag, "_vc"}, 32'(vc_out[k]), 32'd0);
    end
  endtask

  logic [5:0][7:0] prev_line;
  logic [10:0]     prev_hc;
  logic [9:0]      prev_vc;

  always @(negedge clk) begin
    exp_t e;
    check("valid_agree", 32'(dv_out), {26'd0, {6{dv_out[0]}}});
    if (dv_out[0]) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.cyc));
        for (int k = 0; k < 6; k++) check($sformatf("line_k%0d", k), 32'(line_out[k]), 32'(e.line[k]));
        check("hcount", 32'(hc_out[0]), 32'(e.hc));
        check("vcount", 32'(vc_out[0]), 32'(e.vc));
      end
    end else if (!rst_seen) begin
      for (int k = 0; k < 6; k++) check($sformatf("hold_line_k%0d", k), 32'(line_out[k]), 32'(prev_line[k]));
      check("hold_hc", 32'(hc_out[0]), 32'(prev_hc));
      check("hold_vc", 32'(vc_out[0]), 32'(prev_vc));
    end
    prev_line = line_out;
    prev_hc   = hc_out[0];
    prev_vc   = vc_out[0];
  end

  initial begin
    model_clear();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    for (int i = 0; i < 5; i++) drive(1'b1, 8'd100, 8'd100, 8'd100, 11'(i), 10'd7);
    idle(6);
    check("ident_100", 32'(line_out[0]), 32'd100);
    check("ident_vc", 32'(vc_out[0]), 32'd7);
    check("ident_hc", 32'(hc_out[0]), 32'd3);

    for (int i = 0; i < 3; i++) drive(1'b1, 8'd80, 8'd80, 8'd80, 11'(10 + i), 10'd8);
    idle(5);
    check("gauss_80", 32'(line_out[1]), 32'd80);

    drive(1'b1, 8'd0, 8'd0, 8'd0, 11'd20, 10'd9);
    drive(1'b1, 8'd0, 8'd255, 8'd0, 11'd21, 10'd9);
    drive(1'b1, 8'd0, 8'd0, 8'd0, 11'd22, 10'd9);
    idle(5);
    check("gauss_63", 32'(line_out[1]), 32'd63);
    check("sharpen_clamp", 32'(line_out[2]), 32'd255);

    drive(1'b1, 8'd200, 8'd200, 8'd200, 11'd30, 10'd10);
    drive(1'b1, 8'd200, 8'd0, 8'd200, 11'd31, 10'd10);
    drive(1'b1, 8'd200, 8'd200, 8'd200, 11'd32, 10'd10);
    idle(5);
    check("ridge_clamp", 32'(line_out[3]), 32'd0);

    drive(1'b1, 8'd50, 8'd50, 8'd50, 11'd40, 10'd11);
    drive(1'b1, 8'd30, 8'd30, 8'd30, 11'd41, 10'd11);
    drive(1'b1, 8'd10, 8'd10, 8'd10, 11'd42, 10'd11);
    idle(5);
    check("sobelx_160", 32'(line_out[4]), 32'd160);
    drive(1'b1, 8'd10, 8'd10, 8'd10, 11'd43, 10'd11);
    drive(1'b1, 8'd30, 8'd30, 8'd30, 11'd44, 10'd11);
    drive(1'b1, 8'd50, 8'd50, 8'd50, 11'd45, 10'd11);
    idle(5);
    check("sobelx_neg", 32'(line_out[4]), 32'd0);

    begin
      logic [6:0] pat;
      pat = 7'b1011001;
      for (int i = 0; i < 7; i++)
        drive(pat[i], 8'($urandom), 8'($urandom), 8'($urandom), 11'(100 + i), 10'd12);
    end
    idle(6);

    for (int i = 0; i < 40; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
            11'(200 + i), 10'($urandom));
    idle(6);

    for (int i = 0; i < 3; i++) drive(1'b1, 8'(60 + i), 8'(70 + i), 8'(80 + i), 11'(300 + i), 10'd13);
    @(negedge clk);
    rst  = 1'b1;
    vin  = 1'b1;
    lb   = {8'd9, 8'd9, 8'd9};
    hcin = 11'd399;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    vin = 1'b0;
    check_zero("midreset");
    idle(3);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 11'(400 + i), 10'd14);
    idle(8);

    check("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
